// File: rtl/apb_master_arb.sv
// Round-robin arbiter for two command ports feeding a single APB master sequencer.
// Runs SETUP/ACCESS with wait states and a PREADY timeout, and returns data/status to the owning port.
module apb_master_arb #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          hclk,
  input  logic          hreset,
  input  logic          r0_req,
  input  logic          r0_write,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  input  logic          r1_req,
  input  logic          r1_write,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r0_done,
  output logic [DW-1:0] r0_rdata,
  output logic          r0_err,
  output logic          r1_done,
  output logic [DW-1:0] r1_rdata,
  output logic          r1_err,
  output logic          psel,
  output logic          penable,
  output logic          pwrite,
  output logic [AW-1:0] paddr,
  output logic [DW-1:0] pwdata,
  input  logic [DW-1:0] prdata,
  input  logic          pready,
  input  logic          pslverr,
  output logic          busy,
  output logic          owner,
  output logic          timeout_o
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic T_EN = (TIMEOUT > 0) ? 1'b1 : 1'b0;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          owner_q, owner_d;
  logic          psel_q, psel_d;
  logic          penable_q, penable_d;
  logic          pwrite_q, pwrite_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic [DW-1:0] pwdata_q, pwdata_d;
  logic          r0_done_q, r0_done_d;
  logic          r1_done_q, r1_done_d;
  logic [DW-1:0] r0_rdata_q, r0_rdata_d;
  logic [DW-1:0] r1_rdata_q, r1_rdata_d;
  logic          r0_err_q, r0_err_d;
  logic          r1_err_q, r1_err_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;
  logic [TW-1:0] timer_q, timer_d;

  logic          win_s;
  logic          fin_s;
  logic [DW-1:0] fin_rdata_s;
  logic          fin_err_s;

  // Next-state, arbitration and completion capture
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    timer_d      = timer_q;
    timeout_d    = 1'b0;
    win_s        = 1'b0;
    fin_s        = 1'b0;
    fin_rdata_s  = '0;
    fin_err_s    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (r0_req || r1_req) begin
          // On a tie the port that did not win last time is served.
          if (r0_req && r1_req) begin
            win_s = ~last_grant_q;
          end else begin
            win_s = r1_req;
          end
          owner_d      = win_s;
          last_grant_d = win_s;
          pwrite_d     = win_s ? r1_write : r0_write;
          paddr_d      = win_s ? r1_addr  : r0_addr;
          pwdata_d     = win_s ? r1_wdata : r0_wdata;
          timer_d      = '0;
          state_d      = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        timer_d = timer_q + TW'(1);
        if (pready) begin
          fin_s       = 1'b1;
          fin_rdata_s = pwrite_q ? '0 : prdata;
          fin_err_s   = pslverr;
          state_d     = S_DONE;
        end else if (T_EN && (timer_q == T_LAST)) begin
          fin_s     = 1'b1;
          fin_err_s = 1'b1;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          state_d = S_ACCESS;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    r0_done_d  = fin_s & ~owner_q;
    r1_done_d  = fin_s & owner_q;
    r0_rdata_d = (fin_s && !owner_q) ? fin_rdata_s : r0_rdata_q;
    r1_rdata_d = (fin_s && owner_q)  ? fin_rdata_s : r1_rdata_q;
    r0_err_d   = (fin_s && !owner_q) ? fin_err_s   : r0_err_q;
    r1_err_d   = (fin_s && owner_q)  ? fin_err_s   : r1_err_q;

    psel_d    = (state_d == S_SETUP) || (state_d == S_ACCESS);
    penable_d = (state_d == S_ACCESS);
    busy_d    = (state_d != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      r0_done_q    <= 1'b0;
      r1_done_q    <= 1'b0;
      r0_rdata_q   <= '0;
      r1_rdata_q   <= '0;
      r0_err_q     <= 1'b0;
      r1_err_q     <= 1'b0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      r0_done_q    <= r0_done_d;
      r1_done_q    <= r1_done_d;
      r0_rdata_q   <= r0_rdata_d;
      r1_rdata_q   <= r1_rdata_d;
      r0_err_q     <= r0_err_d;
      r1_err_q     <= r1_err_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      timer_q      <= timer_d;
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign r0_done   = r0_done_q;
  assign r1_done   = r1_done_q;
  assign r0_rdata  = r0_rdata_q;
  assign r1_rdata  = r1_rdata_q;
  assign r0_err    = r0_err_q;
  assign r1_err    = r1_err_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Bench for apb_master_arb: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized soak with random resets.
module tb_apb_master_arb;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  logic hclk = 1'b0;
  logic hreset = 1'b1;
  logic r0_req = 1'b0, r0_write = 1'b0, r1_req = 1'b0, r1_write = 1'b0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
  logic r0_done, r1_done, r0_err, r1_err;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic psel, penable, pwrite, busy, owner, timeout_o;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata = '0;
  logic pready = 1'b0, pslverr = 1'b0;

  always #5 hclk = ~hclk;

  apb_master_arb #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .hclk(hclk), .hreset(hreset),
    .r0_req(r0_req), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r1_req(r1_req), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r0_done(r0_done), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_done(r1_done), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .busy(busy), .owner(owner), .timeout_o(timeout_o)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: one in-flight transaction described by how many ACCESS cycles it has had.
  bit m_act, m_fin;
  int m_k, m_last;
  logic e_psel, e_penable, e_pwrite, e_busy, e_owner, e_timeout;
  logic [AW-1:0] e_paddr;
  logic [DW-1:0] e_pwdata, e_rd0, e_rd1;
  logic e_d0, e_d1, e_err0, e_err1;

  // Requesters and slave
  cmd_t q0[$], q1[$];
  bit req_on0 = 1'b0, req_on1 = 1'b0, directed = 1'b1;
  bit slv_rand = 1'b0, slv_err_final = 1'b0, slv_err_wait = 1'b0;
  int slv_wait = 0, slv_p = 7, acc_cnt = 0;
  logic [DW-1:0] slv_data = '0;

  // Traces of DUT outputs for literal checks, index = cycle after the request was seen
  logic tr_psel[0:31], tr_pen[0:31], tr_d0[0:31], tr_d1[0:31], tr_to[0:31];
  logic tr_busy[0:31], tr_pwrite[0:31], tr_err0[0:31], tr_owner[0:31];
  logic [DW-1:0] tr_rd0[0:31], tr_pwdata[0:31];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%h exp=0x%h", name, cyc, act, exp);
    end
  endtask

  function automatic cmd_t rnd_cmd();
    cmd_t c;
    c.wr   = 1'($urandom_range(0, 1));
    c.addr = $urandom & 32'hFFFF_FFFC;
    c.data = $urandom;
    return c;
  endfunction

  task automatic drive_inputs();
    if (!req_on0 && q0.size() > 0 && (directed || $urandom_range(0, 2) == 0)) req_on0 = 1'b1;
    if (!req_on1 && q1.size() > 0 && (directed || $urandom_range(0, 2) == 0)) req_on1 = 1'b1;
    r0_req = req_on0;
    r1_req = req_on1;
    if (req_on0) begin
      r0_write = q0[0].wr; r0_addr = q0[0].addr; r0_wdata = q0[0].data;
    end else begin
      r0_write = 1'($urandom_range(0, 1)); r0_addr = $urandom; r0_wdata = $urandom;
    end
    if (req_on1) begin
      r1_write = q1[0].wr; r1_addr = q1[0].addr; r1_wdata = q1[0].data;
    end else begin
      r1_write = 1'($urandom_range(0, 1)); r1_addr = $urandom; r1_wdata = $urandom;
    end
    if (e_psel && e_penable) begin
      if (slv_rand) begin
        pready  = ($urandom_range(0, 9) < slv_p);
        pslverr = 1'($urandom_range(0, 1));
        prdata  = $urandom;
      end else begin
        pready  = (slv_wait >= 0) && (acc_cnt >= slv_wait);
        pslverr = pready ? slv_err_final : slv_err_wait;
        prdata  = pready ? slv_data : $urandom;
      end
      acc_cnt++;
    end else begin
      acc_cnt = 0;
      pready  = 1'($urandom_range(0, 1));
      pslverr = 1'($urandom_range(0, 1));
      prdata  = $urandom;
    end
  endtask

  task automatic finish_txn(input logic [DW-1:0] rd, input logic err, input logic to);
    m_fin = 1'b1;
    e_psel = 1'b0;
    e_penable = 1'b0;
    e_timeout = to;
    if (e_owner) begin
      e_d1 = 1'b1; e_rd1 = rd; e_err1 = err;
    end else begin
      e_d0 = 1'b1; e_rd0 = rd; e_err0 = err;
    end
  endtask

  // Advances the model over the cycle that is about to end, using the inputs now applied.
  task automatic model_update();
    int win;
    e_d0 = 1'b0; e_d1 = 1'b0; e_timeout = 1'b0;
    if (hreset) begin
      m_act = 1'b0; m_fin = 1'b0; m_k = 0; m_last = 1;
      e_psel = 1'b0; e_penable = 1'b0; e_pwrite = 1'b0; e_paddr = '0; e_pwdata = '0;
      e_busy = 1'b0; e_owner = 1'b0; e_rd0 = '0; e_rd1 = '0; e_err0 = 1'b0; e_err1 = 1'b0;
      return;
    end
    if (!m_act) begin
      if (r0_req || r1_req) begin
        if (r0_req && r1_req) win = 1 - m_last;
        else win = r1_req ? 1 : 0;
        m_last = win; m_act = 1'b1; m_fin = 1'b0; m_k = 0;
        e_owner  = (win == 1);
        e_pwrite = (win == 1) ? r1_write : r0_write;
        e_paddr  = (win == 1) ? r1_addr  : r0_addr;
        e_pwdata = (win == 1) ? r1_wdata : r0_wdata;
        e_psel = 1'b1; e_penable = 1'b0; e_busy = 1'b1;
      end
    end else if (m_fin) begin
      m_act = 1'b0; m_fin = 1'b0;
      e_busy = 1'b0; e_psel = 1'b0; e_penable = 1'b0;
    end else if (m_k == 0) begin
      m_k = 1;
      e_penable = 1'b1;
    end else if (pready) begin
      finish_txn(e_pwrite ? '0 : prdata, pslverr, 1'b0);
    end else if (m_k == TO) begin
      finish_txn('0, 1'b1, 1'b1);
    end else begin
      m_k++;
    end
  endtask

  task automatic compare();
    chk("psel", psel, e_psel);
    chk("penable", penable, e_penable);
    chk("pwrite", pwrite, e_pwrite);
    chk("paddr", paddr, e_paddr);
    chk("pwdata", pwdata, e_pwdata);
    chk("busy", busy, e_busy);
    chk("owner", owner, e_owner);
    chk("timeout_o", timeout_o, e_timeout);
    chk("r0_done", r0_done, e_d0);
    chk("r1_done", r1_done, e_d1);
    chk("r0_rdata", r0_rdata, e_rd0);
    chk("r1_rdata", r1_rdata, e_rd1);
    chk("r0_err", r0_err, e_err0);
    chk("r1_err", r1_err, e_err1);
  endtask

  task automatic step();
    drive_inputs();
    model_update();
    @(posedge hclk);
    #1;
    cyc++;
    compare();
    if (e_d0 && q0.size() > 0) begin q0.delete(0); req_on0 = 1'b0; end
    if (e_d1 && q1.size() > 0) begin q1.delete(0); req_on1 = 1'b0; end
  endtask

  task automatic run(input int n);
    for (int j = 1; j <= n; j++) begin
      step();
      tr_psel[j] = psel; tr_pen[j] = penable; tr_d0[j] = r0_done; tr_d1[j] = r1_done;
      tr_to[j] = timeout_o; tr_busy[j] = busy; tr_pwrite[j] = pwrite; tr_err0[j] = r0_err;
      tr_owner[j] = owner; tr_rd0[j] = r0_rdata; tr_pwdata[j] = pwdata;
    end
  endtask

  task automatic do_reset(input int n);
    hreset = 1'b1;
    repeat (n) step();
    hreset = 1'b0;
  endtask

  function automatic cmd_t mk(input logic wr, input logic [31:0] a, input logic [31:0] d);
    cmd_t c;
    c.wr = wr; c.addr = a; c.data = d;
    return c;
  endfunction

  initial begin
    int n;
    int order[$];
    do_reset(2);
    chk("rst_psel", psel, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_owner", owner, 1'b0);

    // Zero-wait read on port 0
    slv_wait = 0; slv_data = 32'hDEAD_BEEF; slv_err_final = 1'b0; slv_err_wait = 1'b0;
    q0.push_back(mk(1'b0, 32'h4000_0010, 32'h0));
    run(6);
    chk("t1_psel1", tr_psel[1], 1'b1);
    chk("t1_psel2", tr_psel[2], 1'b1);
    chk("t1_psel3", tr_psel[3], 1'b0);
    chk("t1_pen1", tr_pen[1], 1'b0);
    chk("t1_pen2", tr_pen[2], 1'b1);
    chk("t1_done2", tr_d0[2], 1'b0);
    chk("t1_done3", tr_d0[3], 1'b1);
    chk("t1_rdata", tr_rd0[3], 32'hDEAD_BEEF);
    chk("t1_err", tr_err0[3], 1'b0);
    chk("t1_idle", tr_busy[4], 1'b0);

    // Write on port 1 with three wait states
    slv_wait = 3;
    q1.push_back(mk(1'b1, 32'h4000_0004, 32'h1234_5678));
    run(9);
    n = 0;
    for (int c = 1; c <= 9; c++) n += tr_pen[c];
    chk("t2_access_len", n, 4);
    n = 0;
    for (int c = 1; c <= 5; c++) n += (tr_pwrite[c] && tr_pwdata[c] == 32'h1234_5678);
    chk("t2_wdata_stable", n, 5);
    chk("t2_done6", tr_d1[6], 1'b1);
    n = 0;
    for (int c = 1; c <= 9; c++) n += tr_d0[c];
    chk("t2_no_r0_done", n, 0);

    // Contention from reset, two commands per port
    slv_wait = 0; slv_data = 32'hA5A5_0001;
    q0.push_back(mk(1'b0, 32'h4000_0100, 32'h0));
    q0.push_back(mk(1'b1, 32'h4000_0104, 32'h0000_00AA));
    q1.push_back(mk(1'b1, 32'h4000_0200, 32'h0000_00BB));
    q1.push_back(mk(1'b0, 32'h4000_0204, 32'h0));
    do_reset(2);
    run(20);
    for (int c = 1; c <= 20; c++) begin
      if (tr_d0[c]) order.push_back(0);
      if (tr_d1[c]) order.push_back(1);
    end
    chk("t3_ndone", order.size(), 4);
    for (int i = 0; i < 4; i++) chk("t3_order", (i < order.size()) ? order[i] : 9, i % 2);
    chk("t3_rd0", tr_rd0[3], 32'hA5A5_0001);

    // Slave error, then pslverr during wait states that must be ignored
    slv_wait = 0; slv_err_final = 1'b1;
    q0.push_back(mk(1'b0, 32'h4000_0300, 32'h0));
    run(5);
    chk("t4_done", tr_d0[3], 1'b1);
    chk("t4_err", tr_err0[3], 1'b1);
    slv_wait = 2; slv_err_final = 1'b0; slv_err_wait = 1'b1;
    q0.push_back(mk(1'b0, 32'h4000_0304, 32'h0));
    run(8);
    chk("t4b_done", tr_d0[5], 1'b1);
    chk("t4b_err", tr_err0[5], 1'b0);

    // Timeout with pready held low
    slv_wait = -1; slv_err_wait = 1'b0;
    q0.push_back(mk(1'b0, 32'h4000_0400, 32'h0));
    run(12);
    n = 0;
    for (int c = 1; c <= 12; c++) n += tr_pen[c];
    chk("t5_access_len", n, 8);
    n = 0;
    for (int c = 1; c <= 12; c++) n += tr_to[c];
    chk("t5_to_count", n, 1);
    chk("t5_to10", tr_to[10], 1'b1);
    chk("t5_done", tr_d0[10], 1'b1);
    chk("t5_err", tr_err0[10], 1'b1);
    chk("t5_rdata", tr_rd0[10], 32'h0);
    chk("t5_idle", tr_busy[11], 1'b0);

    // Reset during a wait-stated read; the aborted port reissues and wins the tie
    q0.push_back(mk(1'b0, 32'h4000_0500, 32'h0));
    run(3);
    chk("t6_in_access", tr_pen[3], 1'b1);
    hreset = 1'b1;
    step();
    hreset = 1'b0;
    chk("t6_psel", psel, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_nodone", r0_done, 1'b0);
    slv_wait = 0; slv_data = 32'h0BAD_F00D;
    q1.push_back(mk(1'b1, 32'h4000_0600, 32'h5555_AAAA));
    run(8);
    chk("t6_owner", tr_owner[1], 1'b0);
    chk("t6_d0", tr_d0[3], 1'b1);
    chk("t6_rd0", tr_rd0[3], 32'h0BAD_F00D);
    chk("t6_d1", tr_d1[7], 1'b1);

    // Randomized soak
    directed = 1'b0; slv_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) slv_p = $urandom_range(1, 9);
      if (q0.size() < 2 && $urandom_range(0, 3) == 0) q0.push_back(rnd_cmd());
      if (q1.size() < 2 && $urandom_range(0, 3) == 0) q1.push_back(rnd_cmd());
      hreset = ($urandom_range(0, 399) == 0);
      step();
    end
    hreset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
